// File: rtl/ewrapper_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : ewrapper_tx_gearbox
// Description : Word-to-DDR-pair transmit gearbox. Accepts CHANNELS*RATIO-bit
//               words through a one-deep hold register and streams each lane
//               MSB first as (EVEN_OUT, ODD_OUT) pairs, RATIO/2 cycles per word.
//               Optional macro EWRAPPER_TX_TRAIN_EN adds TRAIN_EN, which
//               injects a 1/0 training word at word boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module ewrapper_tx_gearbox #(
  parameter int   CHANNELS   = 9,
  parameter int   RATIO      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                      CLK_IN,
  input  logic                      IO_RESET,
  input  logic                      DATA_IN_VALID,
  input  logic [CHANNELS*RATIO-1:0] DATA_IN,
`ifdef EWRAPPER_TX_TRAIN_EN
  input  logic                      TRAIN_EN,
`endif
  output logic                      DATA_IN_READY,
  output logic [CHANNELS-1:0]       EVEN_OUT,
  output logic [CHANNELS-1:0]       ODD_OUT,
  output logic                      FRAME_OUT,
  output logic                      UNDERRUN
);

  localparam int W    = CHANNELS * RATIO;
  localparam int HALF = RATIO / 2;
  localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0]       C_LAST       = PW'(HALF - 1);
  localparam logic [CHANNELS-1:0] C_IDLE_BITS  = {CHANNELS{IDLE_LEVEL}};
  // Every lane alternates 1,0 from its MSB, so all pairs read EVEN=1, ODD=0.
  localparam logic [W-1:0]        C_TRAIN_WORD = {(W/2){2'b10}};

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [W-1:0]          hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [W-1:0]          active_q, active_d;
  logic [CHANNELS-1:0]   even_q, even_d;
  logic [CHANNELS-1:0]   odd_q, odd_d;
  logic                  frame_q, frame_d;
  logic                  underrun_q, underrun_d;

  logic                  w_boundary;
  logic                  w_train_go;
  logic                  w_load_now;
  logic                  w_accept;

  // Extract pair k of every lane as {even, odd}; pair 0 is the lane MSB pair.
  function automatic logic [2*CHANNELS-1:0] pair_of(input logic [W-1:0] word,
                                                    input logic [PW-1:0] k);
    logic [CHANNELS-1:0] ev;
    logic [CHANNELS-1:0] od;
    logic [RATIO-1:0]    lane;
    ev = '0;
    od = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane  = word[c*RATIO +: RATIO] << {k, 1'b0};
      ev[c] = lane[RATIO-1];
      od[c] = lane[RATIO-2];
    end
    return {ev, od};
  endfunction

  // Next-state, hold-register handshake and output pair selection.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    even_d      = even_q;
    odd_d       = odd_q;
    frame_d     = 1'b0;
    underrun_d  = 1'b0;

    w_boundary = (state_q == S_IDLE) || (phase_q == C_LAST);
`ifdef EWRAPPER_TX_TRAIN_EN
    w_train_go = w_boundary && TRAIN_EN;
`else
    w_train_go = 1'b0;
`endif
    // A training word takes the boundary slot, so the held word waits.
    w_load_now    = hold_full_q && w_boundary && !w_train_go;
    DATA_IN_READY = !IO_RESET && (!hold_full_q || w_load_now);
    w_accept      = DATA_IN_VALID && DATA_IN_READY;

    if (w_train_go || w_load_now) begin
      active_d          = w_train_go ? C_TRAIN_WORD : hold_q;
      {even_d, odd_d}   = pair_of(active_d, '0);
      phase_d           = '0;
      frame_d           = 1'b1;
      state_d           = S_STREAM;
    end else if (state_q == S_STREAM && phase_q != C_LAST) begin
      phase_d           = phase_q + 1'b1;
      {even_d, odd_d}   = pair_of(active_q, phase_d);
    end else if (state_q == S_STREAM) begin
      // Word finished with nothing queued behind it.
      state_d    = S_IDLE;
      phase_d    = '0;
      even_d     = C_IDLE_BITS;
      odd_d      = C_IDLE_BITS;
      underrun_d = 1'b1;
    end else begin
      even_d = C_IDLE_BITS;
      odd_d  = C_IDLE_BITS;
    end

    // Capture overrides drain: accept and load on one edge leaves hold full.
    if (w_accept) begin
      hold_d      = DATA_IN;
      hold_full_d = 1'b1;
    end else if (w_load_now) begin
      hold_full_d = 1'b0;
    end
  end

  // State and registered outputs; reset drops both words silently.
  always_ff @(posedge CLK_IN) begin
    if (IO_RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      even_q      <= C_IDLE_BITS;
      odd_q       <= C_IDLE_BITS;
      frame_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign EVEN_OUT  = even_q;
  assign ODD_OUT   = odd_q;
  assign FRAME_OUT = frame_q;
  assign UNDERRUN  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ewrapper_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_ewrapper_tx_gearbox
// Description : Directed self-checking bench for ewrapper_tx_gearbox, one
//               instance at RATIO=8 and one at RATIO=2 (CHANNELS=9 both).
//               Training case compiled only under EWRAPPER_TX_TRAIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ewrapper_tx_gearbox;

  logic        clk;
  logic        rst;
  logic        v8;
  logic [71:0] d8;
  logic        rdy8;
  logic [8:0]  ev8, od8;
  logic        fr8, ur8;
  logic        v2;
  logic [17:0] d2;
  logic        rdy2;
  logic [8:0]  ev2, od2;
  logic        fr2, ur2;
  logic        train;
  logic        train_off;

  int n_tests = 0;
  int n_fail  = 0;

  ewrapper_tx_gearbox #(.CHANNELS(9), .RATIO(8), .IDLE_LEVEL(1'b0)) u_dut8 (
    .CLK_IN        (clk),
    .IO_RESET      (rst),
    .DATA_IN_VALID (v8),
    .DATA_IN       (d8),
`ifdef EWRAPPER_TX_TRAIN_EN
    .TRAIN_EN      (train),
`endif
    .DATA_IN_READY (rdy8),
    .EVEN_OUT      (ev8),
    .ODD_OUT       (od8),
    .FRAME_OUT     (fr8),
    .UNDERRUN      (ur8)
  );

  ewrapper_tx_gearbox #(.CHANNELS(9), .RATIO(2), .IDLE_LEVEL(1'b0)) u_dut2 (
    .CLK_IN        (clk),
    .IO_RESET      (rst),
    .DATA_IN_VALID (v2),
    .DATA_IN       (d2),
`ifdef EWRAPPER_TX_TRAIN_EN
    .TRAIN_EN      (train_off),
`endif
    .DATA_IN_READY (rdy2),
    .EVEN_OUT      (ev2),
    .ODD_OUT       (od2),
    .FRAME_OUT     (fr2),
    .UNDERRUN      (ur2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pair k of a RATIO=8 word: {even[8:0], odd[8:0]}.
  function automatic logic [17:0] ref8(input logic [71:0] w, input int k);
    logic [8:0] e;
    logic [8:0] o;
    for (int c = 0; c < 9; c++) begin
      e[c] = w[c*8 + 7 - 2*k];
      o[c] = w[c*8 + 6 - 2*k];
    end
    return {e, o};
  endfunction

  function automatic logic [17:0] word2(input int i);
    return 18'(32'h1B6D3 * (i + 1) + 32'h2A5);
  endfunction

  logic [71:0] words [3];
  logic [17:0] exp_pair;
  logic [17:0] w2;
  int          ur_seen;

  initial begin
    words[0] = 72'h7E_81_CC_33_F0_0F_96_C3_5A;
    words[1] = 72'h01_23_45_67_89_AB_CD_EF_10;
    words[2] = 72'hFF_00_A5_5A_3C_C3_69_96_E7;
    rst = 1'b1; v8 = 1'b0; d8 = '0; v2 = 1'b0; d2 = '0;
    train = 1'b0; train_off = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_ready", 72'(rdy8), 72'(1'b0));
    check("rst_even",  72'(ev8),  72'(9'h000));
    check("rst_frame", 72'(fr8),  72'(1'b0));
    check("rst_under", 72'(ur8),  72'(1'b0));
    rst = 1'b0;
    #1;
    check("post_rst_ready", 72'(rdy8), 72'(1'b1));

    // ---------------- single word 0xB4 on lane 0 ----------------
    v8 = 1'b1; d8 = 72'h0000_0000_0000_0000_B4;
    tick();                       // accepted into hold
    v8 = 1'b0; d8 = '0;
    check("b4_latency_frame", 72'(fr8), 72'(1'b0));
    check("b4_latency_even",  72'(ev8), 72'(9'h000));
    tick();                       // pair 0 on the outputs
    check("b4_p0", 72'({ev8, od8, fr8}), 72'({9'h001, 9'h000, 1'b1}));
    tick();
    check("b4_p1", 72'({ev8, od8, fr8}), 72'({9'h001, 9'h001, 1'b0}));
    tick();
    check("b4_p2", 72'({ev8, od8, fr8}), 72'({9'h000, 9'h001, 1'b0}));
    tick();
    check("b4_p3", 72'({ev8, od8, fr8, ur8}), 72'({9'h000, 9'h000, 1'b0, 1'b0}));
    tick();
    check("b4_underrun", 72'({ev8, od8, fr8, ur8}), 72'({9'h000, 9'h000, 1'b0, 1'b1}));
    tick();
    check("b4_underrun_once", 72'(ur8), 72'(1'b0));

    // ---------------- three back-to-back words ----------------
    v8 = 1'b1; d8 = words[0];
    check("str_ready_a", 72'(rdy8), 72'(1'b1));
    tick();
    d8 = words[1];
    check("str_ready_b", 72'(rdy8), 72'(1'b1));
    tick();
    for (int p = 0; p < 12; p++) begin
      exp_pair = ref8(words[p/4], p % 4);
      check($sformatf("str_pair%0d", p), 72'({ev8, od8}), 72'(exp_pair));
      check($sformatf("str_frame%0d", p), 72'({fr8, ur8}), 72'({(p % 4 == 0), 1'b0}));
      if (p == 0) d8 = words[2];
      if (p == 4) v8 = 1'b0;
      #1;
      check($sformatf("str_ready%0d", p), 72'(rdy8), 72'((p >= 8) || (p % 4 == 3)));
      tick();
    end
    check("str_underrun", 72'({ev8, fr8, ur8}), 72'({9'h000, 1'b0, 1'b1}));
    tick();

    // ---------------- reset mid-word with hold full ----------------
    v8 = 1'b1; d8 = words[0];
    tick();
    d8 = words[1];
    tick();
    v8 = 1'b0;
    tick(); tick();               // phase 2, words[1] still held
    check("mid_phase2_pair", 72'({ev8, od8}), 72'(ref8(words[0], 2)));
    rst = 1'b1;
    #1;
    check("mid_ready_in_rst", 72'(rdy8), 72'(1'b0));
    tick();
    check("mid_idle_out", 72'({ev8, od8, fr8, ur8}), 72'(19'h0));
    rst = 1'b0;
    #1;
    check("mid_ready_after", 72'(rdy8), 72'(1'b1));
    ur_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ur8 !== 1'b0 || fr8 !== 1'b0 || ev8 !== 9'h000) ur_seen++;
    end
    check("mid_quiet_after_rst", 72'(ur_seen), 72'(0));

    // ---------------- RATIO=2 sustained throughput ----------------
    for (int i = 0; i < 10; i++) begin
      v2 = 1'b1; d2 = word2(i);
      #1;
      check($sformatf("r2_ready%0d", i), 72'(rdy2), 72'(1'b1));
      tick();
      if (i >= 1) begin
        w2 = word2(i - 1);
        for (int c = 0; c < 9; c++) begin
          exp_pair[9+c] = w2[2*c+1];
          exp_pair[c]   = w2[2*c];
        end
        check($sformatf("r2_word%0d", i - 1), 72'({ev2, od2, fr2, ur2}), 72'({exp_pair, 1'b1, 1'b0}));
      end
    end
    v2 = 1'b0;
    tick();
    w2 = word2(9);
    for (int c = 0; c < 9; c++) begin
      exp_pair[9+c] = w2[2*c+1];
      exp_pair[c]   = w2[2*c];
    end
    check("r2_word9", 72'({ev2, od2, fr2, ur2}), 72'({exp_pair, 1'b1, 1'b0}));
    tick();
    check("r2_underrun", 72'({fr2, ur2}), 72'({1'b0, 1'b1}));

`ifdef EWRAPPER_TX_TRAIN_EN
    // ---------------- training while a word is held ----------------
    tick(); tick();
    v8 = 1'b1; d8 = words[2];
    tick();                       // words[2] held, gearbox idle
    v8 = 1'b0;
    train = 1'b1;
    #1;
    check("trn_ready", 72'(rdy8), 72'(1'b0));
    tick();
    train = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("trn_pat%0d", k), 72'({ev8, od8, fr8, ur8}), 72'({9'h1FF, 9'h000, (k == 0), 1'b0}));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("trn_word%0d", k), 72'({ev8, od8, fr8}), 72'({ref8(words[2], k), (k == 0)}));
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ewrapper_tx_gearbox.md
EWRAPPER_TX_GEARBOX -- requirements
Module: ewrapper_tx_gearbox

Interface
REQ-001 Parameter CHANNELS, default 9, number of serial lanes.
REQ-002 Parameter RATIO, default 8, bits per lane per word; even, 2..16.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, value driven on every lane bit when no word is streaming.
REQ-004 CLK_IN  input  1  fast serialization clock; the only clock; all logic on posedge.
REQ-005 IO_RESET  input  1  synchronous, active-high reset.
REQ-006 DATA_IN_VALID  input  1  source offers DATA_IN.
REQ-007 DATA_IN  input  CHANNELS*RATIO  word; lane c owns bits [c*RATIO +: RATIO].
REQ-008 DATA_IN_READY  output  1  gearbox accepts DATA_IN this cycle.
REQ-009 EVEN_OUT  output  CHANNELS  registered first-half bit per lane (ODDR D1).
REQ-010 ODD_OUT  output  CHANNELS  registered second-half bit per lane (ODDR D2).
REQ-011 FRAME_OUT  output  1  registered; high in the cycle carrying pair 0 of a word.
REQ-012 UNDERRUN  output  1  registered one-cycle pulse when streaming stops for lack of data.
REQ-013 TRAIN_EN  input  1  request training pattern; present only under EWRAPPER_TX_TRAIN_EN.

Function
REQ-014 Storage: one hold register (hold_full flag) and one active shift word; phase counter 0..RATIO/2-1; states IDLE, STREAM.
REQ-015 Transfer occurs when DATA_IN_VALID && DATA_IN_READY at a posedge; word enters hold register.
REQ-016 DATA_IN_READY = !IO_RESET && (!hold_full || load_now); load_now = hold_full && (IDLE || phase==RATIO/2-1). Combinational.
REQ-017 Accept and load in the same edge: hold loads into active word and captures new DATA_IN simultaneously; hold stays full.
REQ-018 Pair k of lane c: EVEN_OUT[c] = word[c*RATIO+RATIO-1-2k], ODD_OUT[c] = word[c*RATIO+RATIO-2-2k] (MSB first).
REQ-019 On a load edge: outputs take pair 0, phase=0, FRAME_OUT=1, state STREAM.
REQ-020 STREAM, phase<RATIO/2-1: phase+1, outputs take next pair, FRAME_OUT=0.
REQ-021 STREAM, phase==RATIO/2-1, hold_full: gapless load of next word (REQ-019).
REQ-022 STREAM, phase==RATIO/2-1, hold empty: state IDLE, outputs IDLE_LEVEL, FRAME_OUT=0, UNDERRUN=1 for one cycle.
REQ-023 IDLE with hold empty: outputs IDLE_LEVEL, UNDERRUN=0; no pulse repeats.
REQ-024 Latency: word accepted at edge T from IDLE with hold empty emits pair 0 after edge T+1.
REQ-025 RATIO=2 sustains one word per cycle with DATA_IN_VALID held high (no gaps, no underrun).

Reset
REQ-026 IO_RESET high at a posedge: hold_full=0, state IDLE, phase 0, EVEN_OUT/ODD_OUT=IDLE_LEVEL, FRAME_OUT=0, UNDERRUN=0.
REQ-027 DATA_IN_READY is 0 while IO_RESET is high; no transfer occurs.
REQ-028 Reset mid-word discards active and held words without UNDERRUN pulse.

Configuration
REQ-029 Macro EWRAPPER_TX_TRAIN_EN defined: TRAIN_EN port exists; at a word boundary (IDLE or phase==RATIO/2-1) with TRAIN_EN high, a training word is emitted instead of loading hold: RATIO/2 cycles of EVEN_OUT=all 1, ODD_OUT=all 0, FRAME_OUT on its first cycle, no UNDERRUN; hold is retained; load_now=0 during training.
REQ-030 Macro undefined: no TRAIN_EN port, no training logic; behaviour per REQ-014..028.

Verification
REQ-031 CHANNELS=9, RATIO=8, one word lane0=8'hB4 others 0 -> lane0 EVEN/ODD pairs (1,0),(1,1),(0,1),(0,0), FRAME_OUT on first, UNDERRUN pulse 4 cycles after first pair.
REQ-032 RATIO=8, VALID held high, 3 words -> 12 contiguous pairs, FRAME_OUT every 4th cycle, READY low while hold full except load edges.
REQ-033 RATIO=2, VALID high 10 cycles -> 10 consecutive FRAME_OUT=1, READY constant 1, no UNDERRUN.
REQ-034 IO_RESET asserted at phase 2 with hold full -> next cycle outputs IDLE_LEVEL, READY 0 during reset, 1 after, no UNDERRUN.
REQ-035 EWRAPPER_TX_TRAIN_EN, TRAIN_EN high while a word is held -> 4 cycles EVEN=9'h1FF/ODD=0, then held word emitted unaltered.
